// File: rtl/div32_seq.sv
// Sequential restoring divider: one quotient bit per clock, signed or unsigned operands.
// Reports divide-by-zero with Q = all ones and R = dividend.
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DZ
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    count;
    logic             neg_q;
    logic             neg_r;
    logic             dz_pend;

    // The shifted partial remainder needs one extra bit.
    // Bit WIDTH of the trial difference is its sign.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted = {rem, dividend[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            Q        <= '0;
            R        <= '0;
            DZ       <= 1'b0;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            count    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz_pend  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        rem   <= '0;
                        count <= '0;
                        if (B == '0) begin
                            dz_pend  <= 1'b1;
                            dividend <= A;
                            state    <= FIN;
                        end else begin
                            // The magnitude of the most negative value is still correct when read as unsigned.
                            dz_pend  <= 1'b0;
                            dividend <= (sign && A[WIDTH-1]) ? -A : A;
                            divisor  <= (sign && B[WIDTH-1]) ? -B : B;
                            neg_q    <= sign & (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_r    <= sign & A[WIDTH-1];
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    // The dividend register fills with quotient bits from the right as it shifts out.
                    if (!trial[WIDTH]) begin
                        rem      <= trial[WIDTH-1:0];
                        dividend <= {dividend[WIDTH-2:0], 1'b1};
                    end else begin
                        rem      <= shifted[WIDTH-1:0];
                        dividend <= {dividend[WIDTH-2:0], 1'b0};
                    end
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    if (dz_pend) begin
                        Q  <= '1;
                        R  <= dividend;
                        DZ <= 1'b1;
                    end else begin
                        Q  <= neg_q ? -dividend : dividend;
                        R  <= neg_r ? -rem : rem;
                        DZ <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed corner cases plus random operands
// compared against a plain-arithmetic reference model.
module tb_div32_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sign;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] Q;
    logic [31:0] R;
    logic        DZ;

    int tests_run;
    int tests_failed;

    div32_seq #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sign (sign),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .Q    (Q),
        .R    (R),
        .DZ   (DZ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 64-bit arithmetic; SV '/' and '%' truncate toward zero.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa, sb, sq, sr;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else begin
            if (s) begin
                sa = longint'(signed'(a));
                sb = longint'(signed'(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[31:0];
            r  = sr[31:0];
            dz = 1'b0;
        end
    endtask

    // Called at a falling edge; returns at the falling edge just after the start edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        start = 1'b1;
        A     = a;
        B     = b;
        sign  = s;
        @(negedge clk);
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        sign  = $urandom_range(0, 1);
    endtask

    // Waits for done and checks timing and results; returns in the done cycle.
    task automatic wait_result(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic s, input int lat);
        logic [31:0] eq, er;
        logic        edz;
        int          k;
        bit          busy_ok;
        model(a, b, s, eq, er, edz);
        k       = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && k < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        tests_run++;
        if (k !== lat) begin
            tests_failed++;
            $display("[TB] FAIL %s latency: got %0d required %0d", name, k, lat);
        end
        tests_run++;
        if (!busy_ok) begin
            tests_failed++;
            $display("[TB] FAIL %s busy dropped before done", name);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s busy in done cycle: got %b required 0", name, busy);
        end
        tests_run++;
        if (Q !== eq) begin
            tests_failed++;
            $display("[TB] FAIL %s Q: got %h required %h", name, Q, eq);
        end
        tests_run++;
        if (R !== er) begin
            tests_failed++;
            $display("[TB] FAIL %s R: got %h required %h", name, R, er);
        end
        tests_run++;
        if (DZ !== edz) begin
            tests_failed++;
            $display("[TB] FAIL %s DZ: got %b required %b", name, DZ, edz);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        sign  = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({busy, done, Q, R, DZ} !== 67'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset outputs: got busy=%b done=%b Q=%h R=%h DZ=%b required all 0",
                     busy, done, Q, R, DZ);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] qh, rh;
        launch(32'd100, 32'd7, 1'b0);
        wait_result("u100/7", 32'd100, 32'd7, 1'b0, 33);
        qh = Q;
        rh = R;
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL done pulse width: got %b required 0", done);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (Q !== qh || R !== rh) begin
            tests_failed++;
            $display("[TB] FAIL result hold: got %h/%h required %h/%h", Q, R, qh, rh);
        end
        launch(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_result("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 33);
        launch(32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_result("s7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 33);
        launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_result("smin/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33);
        launch(32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_result("umax/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 33);
        launch(32'd3, 32'hFFFF_FFFF, 1'b0);
        wait_result("u3/max", 32'd3, 32'hFFFF_FFFF, 1'b0, 33);
        @(negedge clk);
    endtask

    task automatic test_div_by_zero();
        launch(32'd5, 32'd0, 1'b0);
        wait_result("u5/0", 32'd5, 32'd0, 1'b0, 1);
        @(negedge clk);
        launch(32'd5, 32'd0, 1'b1);
        wait_result("s5/0", 32'd5, 32'd0, 1'b1, 1);
        @(negedge clk);
        launch(32'd9, 32'd3, 1'b0);
        wait_result("dz clear", 32'd9, 32'd3, 1'b0, 33);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        launch(32'd100, 32'd7, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1;
        A     = 32'd9;
        B     = 32'd3;
        sign  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_result("ignored restart", 32'd100, 32'd7, 1'b0, 28);
        launch(32'd9, 32'd3, 1'b0);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL done after accept: got %b required 0", done);
        end
        wait_result("start in done cycle", 32'd9, 32'd3, 1'b0, 33);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        bit saw_done;
        launch(32'd100, 32'd7, 1'b0);
        wait_result("pre-reset", 32'd100, 32'd7, 1'b0, 33);
        @(negedge clk);
        launch(32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || Q !== 32'd0 || R !== 32'd0 || done !== 1'b0 || DZ !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async reset: got busy=%b done=%b Q=%h R=%h DZ=%b required all 0",
                     busy, done, Q, R, DZ);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done) begin
            tests_failed++;
            $display("[TB] FAIL aborted op: got done/busy activity required none");
        end
        launch(32'd100, 32'd7, 1'b0);
        wait_result("after reset", 32'd100, 32'd7, 1'b0, 33);
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        s;
        int          lat;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 255);
                2:       b = -($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            s   = $urandom_range(0, 1);
            lat = (b == 32'd0) ? 1 : 33;
            launch(a, b, s);
            wait_result($sformatf("rand%0d %h/%h s=%b", i, a, b, s), a, b, s, lat);
            @(negedge clk);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_directed();
        test_div_by_zero();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
